axil_cfg_responder: RTL

AXI4-lite slave responder serving a bank of 32-bit configuration/status registers, with an interrupt output built from write-1-to-clear status bits. It is the responding end of the CGRA AXI4-lite control interface, the counterpart to the bus master in the Garnet test environment. It lets that master be exercised against a small synthesizable target, and serves as the register front-end for new control blocks. Write and read channels operate independently, with one outstanding transaction per channel.

---
 rtl/axil_cfg_responder_pkg.sv | 29 ++
 rtl/axil_cfg_regbank.sv | 82 ++++++++
 rtl/axil_cfg_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axil_cfg_responder_pkg.sv
// Shared definitions for the AXI4-lite configuration responder.
// Bus widths mirror the CGRA global-buffer AXI parameters (13-bit byte
// address, 32-bit data). The package also holds the response codes and
// the register map indices.
package axil_cfg_responder_pkg;

  // CGRA AXI4-lite control interface widths
  localparam int unsigned CGRA_AXI_ADDR_WIDTH = 13;
  localparam int unsigned CGRA_AXI_DATA_WIDTH = 32;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Register map (word indices)
  localparam int unsigned REG_ID       = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_ENABLE   = 2;
  localparam int unsigned REG_SCRATCH0 = 3;

  localparam int unsigned CFG_NUM_REGS = 16;
  localparam logic [31:0] CFG_ID_VALUE = 32'hC6A0_0001;

  // Response code for a decoded access
  function automatic logic [1:0] axi_resp(input logic in_range);
    return in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axil_cfg_regbank.sv
// Register bank behind the AXI4-lite responder.
// Holds STATUS (write-1-to-clear, set by event pulses), ENABLE, the
// scratch registers and the registered interrupt.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data one write port; wr_en only for in-range indices
//   rd_idx/rd_data       combinational read port (0 when out of range)
//   evt_set              one-cycle pulses setting STATUS bits
//   interrupt            registered |(STATUS & ENABLE)
module axil_cfg_regbank
  import axil_cfg_responder_pkg::*;
#(
  parameter int unsigned           IDX_W      = CGRA_AXI_ADDR_WIDTH - 2,
  parameter int unsigned           DATA_WIDTH = CGRA_AXI_DATA_WIDTH,
  parameter int unsigned           NUM_REGS   = CFG_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = CFG_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [DATA_WIDTH-1:0] evt_set,
  output logic                  interrupt
);

  localparam int unsigned SEL_W = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0] r_enable;
  logic                  r_irq;
  logic [NUM_REGS-1:REG_SCRATCH0][DATA_WIDTH-1:0] r_scratch;
  logic [NUM_REGS-1:REG_SCRATCH0][DATA_WIDTH-1:0] w_scratch_nxt;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]            w_view;

  logic                  w_wr_status;
  logic                  w_wr_enable;
  logic [DATA_WIDTH-1:0] w_w1c_mask;
  logic                  w_rd_in_range;
  logic [SEL_W-1:0]      w_rd_sel;

  assign w_wr_status = wr_en && (wr_idx == IDX_W'(REG_STATUS));
  assign w_wr_enable = wr_en && (wr_idx == IDX_W'(REG_ENABLE));
  assign w_w1c_mask  = w_wr_status ? wr_data : '0;

  // Per-register write decode keeps all array indices constant
  for (genvar g = REG_SCRATCH0; g < NUM_REGS; g++) begin : g_scratch
    assign w_scratch_nxt[g] = (wr_en && (wr_idx == IDX_W'(g))) ? wr_data : r_scratch[g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status  <= '0;
      r_enable  <= '0;
      r_scratch <= '0;
      r_irq     <= 1'b0;
    end else begin
      // Event set is OR-ed after the clear so a same-cycle set wins
      r_status  <= (r_status & ~w_w1c_mask) | evt_set;
      if (w_wr_enable) begin
        r_enable <= wr_data;
      end
      r_scratch <= w_scratch_nxt;
      r_irq     <= |(r_status & r_enable);
    end
  end

  assign interrupt = r_irq;

  // Flat view of the map; ID is a constant, so writes to it go nowhere
  assign w_view[REG_ID]                    = ID_VALUE;
  assign w_view[REG_STATUS]                = r_status;
  assign w_view[REG_ENABLE]                = r_enable;
  assign w_view[NUM_REGS-1:REG_SCRATCH0]   = r_scratch;

  assign w_rd_in_range = 32'(rd_idx) < NUM_REGS;
  assign w_rd_sel      = rd_idx[SEL_W-1:0];
  assign rd_data       = w_rd_in_range ? w_view[w_rd_sel] : '0;

endmodule

// File: rtl/axil_cfg_responder.sv
// AXI4-lite slave responder for a bank of 32-bit config/status registers.
// Write and read channels run independently, one outstanding transaction
// each. AW and W are captured into one-entry holding registers in any
// order; the write commits the cycle after both are held.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   awaddr/awvalid/awready       write address channel
//   wdata/wvalid/wready          write data channel
//   bresp/bvalid/bready          write response channel
//   araddr/arvalid/arready       read address channel
//   rdata/rresp/rvalid/rready    read data channel
//   evt_set                      event pulses setting STATUS bits
//   interrupt                    registered |(STATUS & ENABLE)
module axil_cfg_responder
  import axil_cfg_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = CGRA_AXI_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = CGRA_AXI_DATA_WIDTH,
  parameter int unsigned           NUM_REGS   = CFG_NUM_REGS,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = CFG_ID_VALUE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [DATA_WIDTH-1:0] evt_set,
  output logic                  interrupt
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  logic                  r_aw_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_ar_fire;
  logic                  w_commit;
  logic                  w_aw_in_range;
  logic                  w_ar_in_range;
  logic                  w_reg_we;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [DATA_WIDTH-1:0] w_rb_rdata;
  logic                  w_unused_addr_lsbs;

  // Byte-lane bits of the address carry no meaning for word registers
  assign w_unused_addr_lsbs = &{1'b0, awaddr[1:0], araddr[1:0]};

  // Readies are forced low while reset is asserted so every output is 0
  assign awready = reset_n && !r_aw_held && !r_bvalid;
  assign wready  = reset_n && !r_w_held  && !r_bvalid;
  assign arready = reset_n && !r_rvalid;

  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid  && wready;
  assign w_ar_fire = arvalid && arready;

  // Both holding registers are never full while bvalid is high
  assign w_commit      = r_aw_held && r_w_held;
  assign w_aw_in_range = 32'(r_aw_idx) < NUM_REGS;
  assign w_reg_we      = w_commit && w_aw_in_range;

  assign w_ar_idx      = araddr[ADDR_WIDTH-1:2];
  assign w_ar_in_range = 32'(w_ar_idx) < NUM_REGS;

  // Write channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= axi_resp(w_aw_in_range);
      end else if (r_bvalid && bready) begin
        r_bvalid  <= 1'b0;
      end
    end
  end

  // Read channel; the combinational read port sees pre-commit contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= AXI_RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      if (w_ar_fire) begin
        r_rvalid <= 1'b1;
        r_rresp  <= axi_resp(w_ar_in_range);
        r_rdata  <= w_rb_rdata;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign bvalid = r_bvalid;
  assign bresp  = r_bresp;
  assign rvalid = r_rvalid;
  assign rresp  = r_rresp;
  assign rdata  = r_rdata;

  axil_cfg_regbank #(
    .IDX_W      (IDX_W),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regbank (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (w_reg_we),
    .wr_idx    (r_aw_idx),
    .wr_data   (r_wdata),
    .rd_idx    (w_ar_idx),
    .rd_data   (w_rb_rdata),
    .evt_set   (evt_set),
    .interrupt (interrupt)
  );

endmodule
